// File: rtl/data_mem_responder.sv
// Word-wide load/store responder: latches one request, waits WAIT_CYCLES, then acks.
// state | meaning: IDLE accept req / WAIT count wait states / RESP one-cycle ack
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             mem_q [0:DEPTH-1];

  logic                    err_c;
  logic                    acc_en;
  logic                    acc_we;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [31:0]             acc_wdata;

  always_comb begin
    err_c     = (addr_i[1:0] != 2'b00) | (addr_i[31:ADDR_WIDTH+2] != '0);
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    acc_en    = 1'b0;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          idx_d   = addr_i[ADDR_WIDTH+1:2];
          wdata_d = wdata_i;
          err_d   = err_c;
          if (err_c) begin
            state_d = S_RESP;
            if (!we_i) rdata_d = '0;
          end else if (WAIT_CYCLES == 0) begin
            // Zero wait states: access straight from the inputs on the acceptance edge.
            state_d   = S_RESP;
            acc_en    = 1'b1;
            acc_we    = we_i;
            acc_idx   = addr_i[ADDR_WIDTH+1:2];
            acc_wdata = wdata_i;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          acc_en  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (acc_en && !acc_we) rdata_d = mem_q[acc_idx];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never cleared; reset only blocks a write landing on the same edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (!reset_i && acc_en && acc_we) mem_q[acc_idx] <= acc_wdata;
  end

  assign busy_o  = (state_q != S_IDLE);
  assign ack_o   = (state_q == S_RESP);
  assign err_o   = err_q & ack_o;
  assign rdata_o = rdata_q;

endmodule
